// File: rtl/lsu_mem_port_pkg.sv
// Shared definitions for the load/store unit memory port: funct3 codes,
// FSM state encoding and byte-strobe constants.
package lsu_defs;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_B0   = 4'b0001;
    localparam logic [3:0] STRB_LO   = 4'b0011;
    localparam logic [3:0] STRB_HI   = 4'b1100;
    localparam logic [3:0] STRB_ALL  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Core-side request/response and memory-side handshake signals of the LSU.
// The master modport is the LSU's view; slave is the core+memory environment.
interface lsu_mem_port_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  is_store;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] store_data;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  err_misalign;
    logic                  err_timeout;
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_wstrb;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (
        input  start, is_store, funct3, addr, store_data, mem_rdata, mem_ack,
        output busy, done, load_data, err_misalign, err_timeout,
               mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );

    modport slave (
        output start, is_store, funct3, addr, store_data, mem_rdata, mem_ack,
        input  busy, done, load_data, err_misalign, err_timeout,
               mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );

endinterface

// File: rtl/lsu_mem_port_align.sv
// Combinational lane logic: store steering/strobes, load extraction with
// sign/zero extension, and illegal/misaligned access detection.
module lsu_align
    import lsu_defs::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_ext,
    output logic        err_access
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        misalign;

    always_comb begin
        wdata = '0;
        wstrb = STRB_NONE;
        if (is_store) begin
            case (funct3)
                F3_B: begin
                    wdata = {4{store_data[7:0]}};
                    wstrb = STRB_B0 << offset;
                end
                F3_H: begin
                    wdata = {2{store_data[15:0]}};
                    wstrb = offset[1] ? STRB_HI : STRB_LO;
                end
                F3_W: begin
                    wdata = store_data;
                    wstrb = STRB_ALL;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (offset)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    load_ext = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   load_ext = {24'd0, ld_byte};
            F3_H:    load_ext = {{16{ld_half[15]}}, ld_half};
            F3_HU:   load_ext = {16'd0, ld_half};
            default: load_ext = rdata;
        endcase
    end

    always_comb begin
        case (funct3)
            F3_H, F3_HU: misalign = offset[0];
            F3_W:        misalign = (offset != 2'd0);
            default:     misalign = 1'b0;
        endcase
        err_access = misalign || !f3_legal(is_store, funct3);
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: access FSM, REQ timeout counter and all
// registered outputs toward the core and the data memory.
//   state | meaning
//   IDLE  | waiting for start; latches the access on start
//   REQ   | mem_req held stable until mem_ack or timeout
//   RESP  | one-cycle done pulse with result or error flag
module lsu_mem_port
    import lsu_defs::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    lsu_mem_port_if.master bus
);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    lsu_state_e            state_q;
    logic                  is_store_q;
    logic [2:0]            funct3_q;
    logic [1:0]            offset_q;
    logic [DATA_WIDTH-1:0] store_data_q;
    logic [7:0]            cnt_q;
    logic                  busy_q, done_q, err_misalign_q, err_timeout_q;
    logic                  mem_req_q, mem_we_q;
    logic [DATA_WIDTH-1:0] load_data_q, mem_addr_q, mem_wdata_q;
    logic [3:0]            mem_wstrb_q;

    logic                  idle;
    logic                  is_store_d;
    logic [2:0]            funct3_d;
    logic [1:0]            offset_d;
    logic [DATA_WIDTH-1:0] store_data_d;
    logic [DATA_WIDTH-1:0] wdata, load_ext;
    logic [3:0]            wstrb;
    logic                  err_access;

    // In IDLE the lane logic sees the incoming request; afterwards the latched one.
    assign idle         = (state_q == IDLE);
    assign is_store_d   = idle ? bus.is_store      : is_store_q;
    assign funct3_d     = idle ? bus.funct3        : funct3_q;
    assign offset_d     = idle ? bus.addr[1:0]     : offset_q;
    assign store_data_d = idle ? bus.store_data    : store_data_q;

    lsu_align u_align (
        .is_store   (is_store_d),
        .funct3     (funct3_d),
        .offset     (offset_d),
        .store_data (store_data_d),
        .rdata      (bus.mem_rdata),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .load_ext   (load_ext),
        .err_access (err_access)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            is_store_q     <= 1'b0;
            funct3_q       <= '0;
            offset_q       <= '0;
            store_data_q   <= '0;
            cnt_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_misalign_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            load_data_q    <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wstrb_q    <= STRB_NONE;
            mem_wdata_q    <= '0;
        end else begin
            done_q         <= 1'b0;
            err_misalign_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        is_store_q   <= bus.is_store;
                        funct3_q     <= bus.funct3;
                        offset_q     <= bus.addr[1:0];
                        store_data_q <= bus.store_data;
                        busy_q       <= 1'b1;
                        cnt_q        <= '0;
                        if (err_access) begin
                            state_q        <= RESP;
                            done_q         <= 1'b1;
                            err_misalign_q <= 1'b1;
                        end else begin
                            state_q     <= REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= bus.is_store;
                            mem_addr_q  <= {bus.addr[DATA_WIDTH-1:2], 2'b00};
                            mem_wstrb_q <= wstrb;
                            mem_wdata_q <= wdata;
                        end
                    end
                end
                REQ: begin
                    // mem_ack takes priority over a timeout in the same cycle
                    if (bus.mem_ack || cnt_q == TO_LAST) begin
                        state_q     <= RESP;
                        done_q      <= 1'b1;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wstrb_q <= STRB_NONE;
                        if (!bus.mem_ack)
                            err_timeout_q <= 1'b1;
                        else if (!is_store_q)
                            load_data_q <= load_ext;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.load_data    = load_data_q;
    assign bus.err_misalign = err_misalign_q;
    assign bus.err_timeout  = err_timeout_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wstrb    = mem_wstrb_q;
    assign bus.mem_wdata    = mem_wdata_q;

endmodule
